// File: rtl/data_bus_router_pkg.sv
// Shared types and default address map for data_bus_router.
// Default map covers the system's RAM, IO, UART0 and mtimer regions.
package data_bus_router_pkg;

    localparam int MAX_SLV = 16;

    typedef logic [$clog2(MAX_SLV)-1:0] slv_idx_t;

    // RAM, IO, UART0, mtimer: one 256 MiB region each.
    localparam logic [31:0] DEF_SLV_BASE [4] = '{32'h0000_0000, 32'h1000_0000,
                                                 32'h2000_0000, 32'h3000_0000};
    localparam logic [31:0] DEF_SLV_MASK [4] = '{default: 32'hF000_0000};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_MISS
    } state_t;

endpackage

// File: rtl/data_bus_router_dec.sv
// Combinational base/mask address decoder: one-hot hit (lowest index wins),
// the encoded slave index, and a miss flag when nothing matches.
module data_bus_router_dec
    import data_bus_router_pkg::*;
#(
    parameter int                N_SLV            = 4,
    parameter int                ADDR_W           = 32,
    parameter logic [ADDR_W-1:0] SLV_BASE [N_SLV] = DEF_SLV_BASE,
    parameter logic [ADDR_W-1:0] SLV_MASK [N_SLV] = DEF_SLV_MASK
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic [N_SLV-1:0]  o_hit,
    output slv_idx_t          o_sel,
    output logic              o_miss
);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        o_hit  = '0;
        o_sel  = '0;
        o_miss = 1'b1;
        // Scan downwards so the lowest matching index is the last one written.
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if ((i_addr & SLV_MASK[i]) == SLV_BASE[i]) begin
                o_hit    = '0;
                o_hit[i] = 1'b1;
                o_sel    = slv_idx_t'(i);
                o_miss   = 1'b0;
            end
        end
    end

endmodule

// File: rtl/data_bus_router.sv
// Routes the core's OBI data port to one of N_SLV slaves, one transaction outstanding.
// Define DATA_BUS_ROUTER_TIMEOUT_EN to return a bus error when a slave hangs.
module data_bus_router
    import data_bus_router_pkg::*;
#(
    parameter int                N_SLV            = 4,
    parameter int                ADDR_W           = 32,
    parameter int                DATA_W           = 32,
    parameter logic [ADDR_W-1:0] SLV_BASE [N_SLV] = DEF_SLV_BASE,
    parameter logic [ADDR_W-1:0] SLV_MASK [N_SLV] = DEF_SLV_MASK,
    parameter int                TIMEOUT          = 64
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    m_req,
    input  logic                    m_we,
    input  logic [ADDR_W-1:0]       m_addr,
    input  logic [DATA_W/8-1:0]     m_be,
    input  logic [DATA_W-1:0]       m_wdata,
    output logic                    m_gnt,
    output logic                    m_rvalid,
    output logic                    m_err,
    output logic [DATA_W-1:0]       m_rdata,
    output logic [N_SLV-1:0]        s_req,
    output logic                    s_we,
    output logic [ADDR_W-1:0]       s_addr,
    output logic [DATA_W/8-1:0]     s_be,
    output logic [DATA_W-1:0]       s_wdata,
    input  logic [N_SLV-1:0]        s_gnt,
    input  logic [N_SLV-1:0]        s_rvalid,
    input  logic [N_SLV-1:0]        s_err,
    input  logic [N_SLV*DATA_W-1:0] s_rdata,
    output logic                    stat_miss,
    output logic                    stat_timeout
);

    if (N_SLV < 1 || N_SLV > MAX_SLV || TIMEOUT < 2) begin : g_param_check
        $error("data_bus_router: N_SLV must be 1..16 and TIMEOUT at least 2");
    end

    state_t            r_state;
    state_t            w_next;
    slv_idx_t          r_pend;
    logic [N_SLV-1:0]  w_hit;
    slv_idx_t          w_sel;
    logic              w_miss;
    logic              w_pend_rvalid;
    logic              w_pend_err;
    logic [DATA_W-1:0] w_pend_rdata;
    logic              w_resp;
    logic              w_timeout;
    logic              w_can_issue;
    logic              w_accept;

    data_bus_router_dec #(
        .N_SLV    (N_SLV),
        .ADDR_W   (ADDR_W),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_dec (
        .i_addr (m_addr),
        .o_hit  (w_hit),
        .o_sel  (w_sel),
        .o_miss (w_miss)
    );

    assign s_we    = m_we;
    assign s_addr  = m_addr;
    assign s_be    = m_be;
    assign s_wdata = m_wdata;

    always_comb begin
        w_pend_rvalid = 1'b0;
        w_pend_err    = 1'b0;
        w_pend_rdata  = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (r_pend == slv_idx_t'(i)) begin
                w_pend_rvalid = s_rvalid[i];
                w_pend_err    = s_err[i];
                w_pend_rdata  = s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // A new request may issue when idle or in the cycle the pending one completes.
    assign w_resp      = (r_state == ST_WAIT) && w_pend_rvalid;
    assign w_can_issue = !Rst && ((r_state == ST_IDLE) || w_resp);
    assign m_gnt       = w_can_issue && (w_miss || |(w_hit & s_gnt));
    assign s_req       = (m_req && w_can_issue) ? w_hit : '0;
    assign w_accept    = m_req && m_gnt;
    assign stat_miss   = w_accept && w_miss;

`ifdef DATA_BUS_ROUTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_cnt <= '0;
        end else if (w_accept && !w_miss) begin
            r_cnt <= CNT_W'(1);
        end else if ((r_state == ST_WAIT) && (r_cnt != CNT_W'(TIMEOUT))) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_timeout = (r_state == ST_WAIT) && !w_pend_rvalid && (r_cnt == CNT_W'(TIMEOUT));
`else
    assign w_timeout = 1'b0;
`endif

    assign stat_timeout = w_timeout;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= ST_IDLE;
            r_pend  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept && !w_miss) begin
                r_pend <= w_sel;
            end
        end
    end

    always_comb begin
        w_next   = r_state;
        m_rvalid = 1'b0;
        m_err    = 1'b0;
        m_rdata  = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = w_miss ? ST_MISS : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_resp) begin
                    m_rvalid = 1'b1;
                    m_err    = w_pend_err;
                    m_rdata  = w_pend_rdata;
                    if (w_accept) begin
                        w_next = w_miss ? ST_MISS : ST_WAIT;
                    end else begin
                        w_next = ST_IDLE;
                    end
                end else if (w_timeout) begin
                    m_rvalid = 1'b1;
                    m_err    = 1'b1;
                    w_next   = ST_IDLE;
                end
            end
            ST_MISS: begin
                m_rvalid = 1'b1;
                m_err    = 1'b1;
                w_next   = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

endmodule

// File: doc/data_bus_router.md
# data_bus_router

Parametrised N-slave router for the core's OBI-style data port. It decodes each request against a base/mask address map and forwards it to exactly one slave. It tracks the one outstanding transaction so the response is taken only from the slave that was addressed. Unmapped addresses and hung slaves get a bus error response. It sits between the core data interface and the peripheral/RAM ports of the FPGA system.

## Interface
- N_SLV, 4: number of slave ports (1..16).
- ADDR_W, 32: address width.
- DATA_W, 32: data width; byte-enable width is DATA_W/8.
- SLV_BASE, {32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000}: per-slave base address (array of N_SLV × ADDR_W).
- SLV_MASK, {N_SLV{32'hF000_0000}}: per-slave decode mask.
- TIMEOUT, 64: cycles a slave may take to respond (≥2). Used only with the timeout feature.
- Clk  in  1  clock.
- Rst  in  1  reset, asynchronous, active-high.
- m_req, m_we  in  1  master request / write.
- m_addr  in  ADDR_W  master address.
- m_be  in  DATA_W/8  byte enables.
- m_wdata  in  DATA_W  write data.
- m_gnt  out  1  request accepted.
- m_rvalid, m_err  out  1  response valid / error.
- m_rdata  out  DATA_W  read data.
- s_req  out  N_SLV  one-hot slave request.
- s_we, s_addr, s_be, s_wdata  out  broadcast copies of the master fields.
- s_gnt, s_rvalid, s_err  in  N_SLV  per-slave grant / response valid / error.
- s_rdata  in  N_SLV×DATA_W  per-slave read data, slave i at bits [i*DATA_W +: DATA_W].
- stat_miss, stat_timeout  out  1  single-cycle event pulses.

## Operation
- Decode: slave i hits when (m_addr & SLV_MASK[i]) == SLV_BASE[i]. If several slaves hit, the lowest index wins. No hit is a miss.
- FSM states:
  - IDLE: no transaction outstanding.
  - WAIT: a slave transaction is outstanding. Registers `pend` (slave index) and `cnt`.
  - MISS: a decode-error response is owed.
- s_req[i] = m_req & hit_i & can_issue, where can_issue = IDLE, or WAIT & s_rvalid[pend].
- m_gnt = can_issue & (hit ? s_gnt[sel] : 1). Handshake happens when m_req & m_gnt.
- Accept on a hit: pend←sel, cnt←1, next state WAIT.
- Accept on a miss: next state MISS, stat_miss pulses.
- In WAIT, when s_rvalid[pend] is high:
  - m_rvalid=1, m_rdata=s_rdata[pend], m_err=s_err[pend].
  - Go to IDLE, unless a new request is accepted in the same cycle (back-to-back). Then take that request's transition.
- MISS: m_rvalid=1, m_err=1, m_rdata=0 for one cycle. m_gnt=0. Then go to IDLE.
- s_rvalid from any slave other than pend, or while in IDLE/MISS, is ignored.
- m_rdata=0 whenever m_rvalid=0.
- Reset mid-transaction: the pending transaction is dropped with no response. A slave response arriving after reset is ignored.

## Timing
- Reset values: state IDLE, pend 0, cnt 0. All outputs 0, and m_gnt is forced 0 while Rst is high.
- Request path is combinational: s_req is asserted in the same cycle T as m_req.
- Response path is combinational: m_rvalid appears in the same cycle as s_rvalid[pend].
- A zero-wait slave that responds at T+1 sustains one transaction per cycle.
- Miss: error response in cycle T+1. The next grant is possible in T+2.
- Only one transaction is ever outstanding. In WAIT, m_gnt stays 0 until the response cycle.

## Configuration
- DATA_BUS_ROUTER_TIMEOUT_EN defined:
  - cnt (width $clog2(TIMEOUT+1)) increments every WAIT cycle, saturating.
  - If cnt==TIMEOUT and s_rvalid[pend]=0: m_rvalid=1, m_err=1, m_rdata=0, stat_timeout pulses, state goes to IDLE. No grant is given in that cycle.
  - A slave response in the same cycle takes priority over the timeout.
  - A late response after a timeout is ignored.
- Not defined: no counter is built, WAIT lasts indefinitely, and stat_timeout is tied to 0.

## Structure
- Package data_bus_router_pkg holds:
  - the slave index type,
  - the default SLV_BASE/SLV_MASK constants, which match the system memory map for RAM, IO, UART0 and mtimer,
  - the state enum.
- Sub-module data_bus_router_dec: purely combinational. Inputs m_addr and the map; outputs one-hot hit, the encoded sel, and miss.

## Test plan
- Read of 0x1000_0004 with slave 1 giving s_gnt=1 at T and s_rvalid=1, s_rdata=0xDEAD_BEEF at T+3 -> s_req=4'b0010 at T; m_rvalid=1, m_rdata=0xDEAD_BEEF, m_err=0 at T+3 only.
- Write to 0x4000_0000 (unmapped) -> m_gnt=1 at T; stat_miss at T; m_rvalid=1, m_err=1, m_rdata=0 at T+1; no s_req bit set.
- Back-to-back reads to slaves 0 and 2, each responding one cycle after its request -> grants at T and T+1, responses at T+1 and T+2, each with the correct rdata.
- Stray s_rvalid[3]=1, s_rdata=0x1234 while slave 0 is pending -> m_rvalid stays 0 until s_rvalid[0].
- Timeout enabled, TIMEOUT=64, slave 2 never responds -> m_rvalid=1, m_err=1 and stat_timeout at T+64; a late s_rvalid[2] at T+70 is ignored.
- Rst pulsed at T+2 while WAIT on slave 1 -> all outputs 0; state returns to IDLE; an s_rvalid[1] after reset produces no m_rvalid.
